// File: rtl/axi_lite_cfg_regs_if.sv
// AXI4-Lite bundle shared by the configuration crossbar and its register responders.
// Master drives requests and the response ready signals; Slave answers.
interface AXI_LITE #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
);
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic                      aw_valid;
  logic                      aw_ready;
  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_valid;
  logic                      w_ready;
  logic [1:0]                b_resp;
  logic                      b_valid;
  logic                      b_ready;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic                      ar_valid;
  logic                      ar_ready;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );

  modport Slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );
endinterface

// File: rtl/axi_lite_cfg_regs.sv
// AXI-Lite configuration register bank: N_REGS word registers with byte-lane writes,
// per-register write pulses and independent single-outstanding read/write channels.
module axi_lite_cfg_regs #(
  parameter int ADDR_BITW = 32,
  parameter int DATA_BITW = 32,
  parameter int N_REGS    = 16
) (
  input  logic                        Clk_CI,
  input  logic                        Rst_RBI,
  AXI_LITE.Slave                      Slave_PS,
  output logic [N_REGS*DATA_BITW-1:0] Regs_DO,
  output logic [N_REGS-1:0]           WrPulse_SO
);
  localparam int DATA_BYTEW = DATA_BITW / 8;
  localparam int IDX_BITW   = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam logic [ADDR_BITW:0] LP_NREGS = (ADDR_BITW+1)'(N_REGS);

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} r_state_e;

  w_state_e r_wstate, w_wstate_nxt;
  r_state_e r_rstate, w_rstate_nxt;

  logic [N_REGS-1:0][DATA_BITW-1:0] r_regs;
  logic [N_REGS-1:0]                r_wr_pulse;
  logic [1:0]                       r_bresp;
  logic [1:0]                       r_rresp;
  logic [DATA_BITW-1:0]             r_rdata;

  logic [ADDR_BITW-1:0] w_aw_idx;
  logic [ADDR_BITW-1:0] w_ar_idx;
  logic [IDX_BITW-1:0]  w_aw_sel;
  logic [IDX_BITW-1:0]  w_ar_sel;
  logic                 w_aw_in;
  logic                 w_ar_in;
  logic                 w_wr_hs;
  logic                 w_wr_hit;
  logic                 w_rd_hs;
  logic                 w_ar_rdy;

  function automatic logic [DATA_BITW-1:0] f_merge(
    input logic [DATA_BITW-1:0]  old_v,
    input logic [DATA_BITW-1:0]  new_v,
    input logic [DATA_BYTEW-1:0] strb
  );
    logic [DATA_BITW-1:0] res;
    res = old_v;
    for (int b = 0; b < DATA_BYTEW; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return res;
  endfunction

  assign w_aw_idx = Slave_PS.aw_addr / ADDR_BITW'(DATA_BYTEW);
  assign w_ar_idx = Slave_PS.ar_addr / ADDR_BITW'(DATA_BYTEW);
  assign w_aw_in  = ({1'b0, w_aw_idx} < LP_NREGS);
  assign w_ar_in  = ({1'b0, w_ar_idx} < LP_NREGS);
  assign w_aw_sel = w_aw_idx[IDX_BITW-1:0];
  assign w_ar_sel = w_ar_idx[IDX_BITW-1:0];

  // Address and data are only ever taken together; the reset term keeps ready low in reset.
  assign w_wr_hs  = Rst_RBI && (r_wstate == W_IDLE) && Slave_PS.aw_valid && Slave_PS.w_valid;
  assign w_wr_hit = w_wr_hs && w_aw_in;
  assign w_ar_rdy = Rst_RBI && (r_rstate == R_IDLE);
  assign w_rd_hs  = w_ar_rdy && Slave_PS.ar_valid;

  assign Slave_PS.aw_ready = w_wr_hs;
  assign Slave_PS.w_ready  = w_wr_hs;
  assign Slave_PS.ar_ready = w_ar_rdy;
  assign Slave_PS.b_valid  = (r_wstate == W_RESP);
  assign Slave_PS.b_resp   = r_bresp;
  assign Slave_PS.r_valid  = (r_rstate == R_RESP);
  assign Slave_PS.r_data   = r_rdata;
  assign Slave_PS.r_resp   = r_rresp;
  assign Regs_DO           = r_regs;
  assign WrPulse_SO        = r_wr_pulse;

  // Write channel state register.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_wstate <= W_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
    end
  end

  // Write channel next state; the b handshake returns to idle without accepting a new write.
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE: begin
        if (w_wr_hs) begin
          w_wstate_nxt = W_RESP;
        end else begin
          w_wstate_nxt = W_IDLE;
        end
      end
      W_RESP: begin
        if (Slave_PS.b_ready) begin
          w_wstate_nxt = W_IDLE;
        end else begin
          w_wstate_nxt = W_RESP;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Register update, write pulse and write response code.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_regs     <= '0;
      r_wr_pulse <= '0;
      r_bresp    <= 2'b00;
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        r_wr_pulse[i] <= w_wr_hit && (w_aw_sel == IDX_BITW'(i));
        if (w_wr_hit && (w_aw_sel == IDX_BITW'(i))) begin
          r_regs[i] <= f_merge(r_regs[i], Slave_PS.w_data, Slave_PS.w_strb);
        end
      end
      if (w_wr_hs) begin
        r_bresp <= w_aw_in ? 2'b00 : 2'b10;
      end
    end
  end

  // Read channel state register.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_rstate <= R_IDLE;
    end else begin
      r_rstate <= w_rstate_nxt;
    end
  end

  // Read channel next state.
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE: begin
        if (w_rd_hs) begin
          w_rstate_nxt = R_RESP;
        end else begin
          w_rstate_nxt = R_IDLE;
        end
      end
      R_RESP: begin
        if (Slave_PS.r_ready) begin
          w_rstate_nxt = R_IDLE;
        end else begin
          w_rstate_nxt = R_RESP;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read data capture samples the pre-edge register value, so a colliding write reads old data.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_rdata <= '0;
      r_rresp <= 2'b00;
    end else if (w_rd_hs) begin
      r_rdata <= w_ar_in ? r_regs[w_ar_sel] : '0;
      r_rresp <= w_ar_in ? 2'b00 : 2'b10;
    end
  end
endmodule

// File: doc/axi_lite_cfg_regs.md
AXI_LITE_CFG_REGS -- requirements
Module: axi_lite_cfg_regs

Interface
REQ-001 SHALL have parameter ADDR_BITW, default 32: AXI-Lite address width.
REQ-002 SHALL have parameter DATA_BITW, default 32: AXI-Lite data and register width, a multiple of 8.
REQ-003 SHALL have parameter N_REGS, default 16: number of registers, range 1..256.
REQ-004 SHALL have port Clk_CI, input, 1 bit: single clock; all logic rising-edge.
REQ-005 SHALL have port Rst_RBI, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port Slave_PS, AXI_LITE.Slave, ADDR_BITW/DATA_BITW: configuration responder, i.e. the far end of the config crossbar master port.
REQ-007 SHALL have port Regs_DO, output, N_REGS*DATA_BITW bits: register contents; register i occupies bits [i*DATA_BITW +: DATA_BITW].
REQ-008 SHALL have port WrPulse_SO, output, N_REGS bits: one-cycle pulse on bit i when register i is written.

Function
REQ-009 SHALL define DATA_BYTEW = DATA_BITW/8 and register index idx = addr / DATA_BYTEW; the low address bits below the byte-lane width are ignored.
REQ-010 SHALL treat idx >= N_REGS as out of range.
REQ-011 SHALL run a write FSM with states W_IDLE and W_RESP.
REQ-012 SHALL assert aw_ready and w_ready, in W_IDLE only, in the same cycle when aw_valid and w_valid are both high; both handshakes complete together, and a lone aw_valid or w_valid SHALL NOT be accepted.
REQ-013 On a write handshake at cycle T, SHALL update the in-range register at edge T+1, per byte lane where w_strb is 1, leaving other lanes unchanged, and SHALL pulse WrPulse_SO[idx] in cycle T+1 (pulse fires even if w_strb is 0).
REQ-014 SHALL enter W_RESP at T+1 with b_valid=1 and b_resp = 2'b00 when in range or 2'b10 (SLVERR) when out of range; an out-of-range write SHALL change no register and raise no pulse.
REQ-015 SHALL hold b_valid and b_resp stable in W_RESP until b_ready; on the b handshake SHALL return to W_IDLE with b_valid=0, and SHALL NOT accept a new write in that same cycle.
REQ-016 SHALL run an independent read FSM with states R_IDLE and R_RESP; ar_ready SHALL be 1 exactly in R_IDLE.
REQ-017 On a read handshake at cycle T, SHALL present r_valid=1 in cycle T+1 with registered r_data equal to the register value before edge T+1 and r_resp = 2'b00; out of range SHALL give r_data=0 and r_resp=2'b10.
REQ-018 SHALL hold r_valid, r_data and r_resp stable in R_RESP until r_ready; on the handshake SHALL return to R_IDLE.
REQ-019 When a read and a write to the same register handshake in the same cycle, the read SHALL return the old value.
REQ-020 Read and write channels SHALL progress concurrently with no mutual stalling.
REQ-021 Maximum throughput SHALL be one write per 2 cycles and one read per 2 cycles when b_ready and r_ready are held high.

Reset
REQ-022 On Rst_RBI low, SHALL immediately and asynchronously clear: all registers, Regs_DO, WrPulse_SO, b_valid, r_valid, r_data, b_resp, r_resp; aw_ready, w_ready and ar_ready SHALL be 0, and both FSMs SHALL enter IDLE.
REQ-023 Reset asserted mid-transaction SHALL discard the pending response; after release, ar_ready SHALL be 1 in the first cycle.

Verification
REQ-024 Write 0xDEADBEEF to addr 0x8, strb 0xF, with b_ready=1 -> b_valid one cycle after handshake, b_resp=00, Regs_DO reg2=0xDEADBEEF, WrPulse_SO=0x0004 for one cycle.
REQ-025 Write 0x000000AA to addr 0x8, strb 0x1, over reg2=0xDEADBEEF -> reg2=0xDEADBEAA; then a read of 0x8 returns r_data=0xDEADBEAA, r_resp=00.
REQ-026 Write and read to addr 0x40 with N_REGS=16 -> b_resp=10, r_resp=10, r_data=0, no register change, WrPulse_SO=0.
REQ-027 aw_valid held 3 cycles before w_valid -> no aw_ready until w_valid is high, then both ready in the same cycle; b_ready low 4 cycles -> b_valid and b_resp stable throughout.
REQ-028 Same-cycle write 0x1 and read to reg0 (old value 0x0) -> r_data=0x0, reg0=0x1 afterward; both responses delivered.
REQ-029 Rst_RBI pulsed low while r_valid=1 -> r_valid=0 and all registers 0 immediately; after release a read of 0x0 returns 0x0.
